// File: rtl/serial_sched.sv
// Round-robin scheduler sharing one CORE-lane parallel-to-serial shifter between
// NREQ producers; emits the shifter load strobe plus per-element buffer writes.
module serial_sched #(
    parameter int CORE   = 16,
    parameter int NREQ   = 4,
    parameter int LWIDTH = 5,
    parameter int AWIDTH = 12,
    parameter int SWIDTH = 2
) (
    input  logic                   clk,
    input  logic                   xrst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*LWIDTH-1:0] req_len,
    input  logic [NREQ*AWIDTH-1:0] req_base,
    output logic [NREQ-1:0]        gnt,
    output logic [SWIDTH-1:0]      sel,
    output logic                   serial_we,
    output logic                   mem_we,
    output logic [AWIDTH-1:0]      mem_addr,
    output logic                   busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;

    localparam logic [LWIDTH-1:0] FULL_LEN = LWIDTH'(CORE);

    logic [1:0]        state_q, state_d;
    logic [SWIDTH-1:0] ptr_q, ptr_d;
    logic [LWIDTH-1:0] len_q, len_d;
    logic [LWIDTH-1:0] k_q, k_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [SWIDTH-1:0] sel_q, sel_d;
    logic              serial_we_q, serial_we_d;
    logic              mem_we_q, mem_we_d;
    logic [AWIDTH-1:0] mem_addr_q, mem_addr_d;
    logic              busy_q, busy_d;

    logic [LWIDTH-1:0] len_arr  [NREQ];
    logic [AWIDTH-1:0] base_arr [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign len_arr[g]  = req_len[g*LWIDTH +: LWIDTH];
        assign base_arr[g] = req_base[g*AWIDTH +: AWIDTH];
    end

    // Round-robin pick: first set request at or after the pointer, with wrap.
    logic              any_req;
    logic [SWIDTH-1:0] win;
    logic [SWIDTH-1:0] cand;
    int                scan_idx;

    always_comb begin
        any_req  = 1'b0;
        win      = '0;
        cand     = '0;
        scan_idx = 0;
        for (int i = 0; i < NREQ; i++) begin
            scan_idx = int'(ptr_q) + i;
            if (scan_idx >= NREQ) begin
                scan_idx = scan_idx - NREQ;
            end
            cand = SWIDTH'(scan_idx);
            if (!any_req && req[cand]) begin
                any_req = 1'b1;
                win     = cand;
            end
        end
    end

    logic start_load;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        state_d     = state_q;
        ptr_d       = ptr_q;
        len_d       = len_q;
        k_d         = k_q;
        addr_d      = addr_q;
        gnt_d       = '0;
        sel_d       = sel_q;
        serial_we_d = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        start_load  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                start_load = any_req;
            end
            ST_LOAD: begin
                state_d    = ST_SHIFT;
                k_d        = '0;
                mem_we_d   = 1'b1;
                mem_addr_d = addr_q;
            end
            ST_SHIFT: begin
                if (k_q == len_q - LWIDTH'(1)) begin
                    start_load = any_req;
                    state_d    = ST_IDLE;
                end else begin
                    k_d        = k_q + LWIDTH'(1);
                    mem_we_d   = 1'b1;
                    mem_addr_d = addr_q + AWIDTH'(k_q) + AWIDTH'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (start_load) begin
            state_d     = ST_LOAD;
            gnt_d[win]  = 1'b1;
            sel_d       = win;
            serial_we_d = 1'b1;
            addr_d      = base_arr[win];
            // Zero or oversize lengths mean a full vector.
            if (len_arr[win] == '0 || len_arr[win] > FULL_LEN) begin
                len_d = FULL_LEN;
            end else begin
                len_d = len_arr[win];
            end
            if (win == SWIDTH'(NREQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = win + SWIDTH'(1);
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            len_q       <= '0;
            k_q         <= '0;
            addr_q      <= '0;
            gnt_q       <= '0;
            sel_q       <= '0;
            serial_we_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            len_q       <= len_d;
            k_q         <= k_d;
            addr_q      <= addr_d;
            gnt_q       <= gnt_d;
            sel_q       <= sel_d;
            serial_we_q <= serial_we_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            busy_q      <= busy_d;
        end
    end

    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign serial_we = serial_we_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_serial_sched.sv
// Bench for serial_sched: transaction-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_serial_sched;

    localparam int CORE   = 16;
    localparam int NREQ   = 4;
    localparam int LWIDTH = 5;
    localparam int AWIDTH = 12;
    localparam int SWIDTH = 2;

    logic                   clk = 1'b0;
    logic                   xrst;
    logic [NREQ-1:0]        req;
    logic [NREQ*LWIDTH-1:0] req_len;
    logic [NREQ*AWIDTH-1:0] req_base;
    logic [NREQ-1:0]        gnt;
    logic [SWIDTH-1:0]      sel;
    logic                   serial_we;
    logic                   mem_we;
    logic [AWIDTH-1:0]      mem_addr;
    logic                   busy;

    serial_sched #(
        .CORE(CORE), .NREQ(NREQ), .LWIDTH(LWIDTH), .AWIDTH(AWIDTH), .SWIDTH(SWIDTH)
    ) dut (
        .clk(clk), .xrst(xrst), .req(req), .req_len(req_len), .req_base(req_base),
        .gnt(gnt), .sel(sel), .serial_we(serial_we), .mem_we(mem_we),
        .mem_addr(mem_addr), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t actual=0x%0h expected=0x%0h", name, $time, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Reference model: each granted vector is a list of cycles (1 load + len writes).
    typedef struct packed {
        logic [NREQ-1:0]   gnt;
        logic [SWIDTH-1:0] sel;
        logic              swe;
        logic              mwe;
        logic [AWIDTH-1:0] addr;
        logic              busy;
    } exp_t;

    exp_t                   mq[$];
    exp_t                   exp_o;
    exp_t                   ent;
    int                     m_ptr;
    int                     m_w, m_len, m_base;
    logic [NREQ*LWIDTH-1:0] len_sh;
    logic [NREQ*AWIDTH-1:0] base_sh;

    always @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            mq.delete();
            m_ptr = 0;
            exp_o = '0;
        end else begin
            if (mq.size() == 0 && req != '0) begin
                m_w = -1;
                for (int i = 0; i < NREQ; i++) begin
                    if (m_w < 0 && req[(m_ptr + i) % NREQ]) m_w = (m_ptr + i) % NREQ;
                end
                len_sh  = req_len >> (m_w * LWIDTH);
                base_sh = req_base >> (m_w * AWIDTH);
                m_len   = int'(len_sh[LWIDTH-1:0]);
                m_base  = int'(base_sh[AWIDTH-1:0]);
                if (m_len == 0 || m_len > CORE) m_len = CORE;
                ent      = '0;
                ent.gnt  = NREQ'(1) << m_w;
                ent.sel  = SWIDTH'(m_w);
                ent.swe  = 1'b1;
                ent.busy = 1'b1;
                mq.push_back(ent);
                for (int k = 0; k < m_len; k++) begin
                    ent      = '0;
                    ent.sel  = SWIDTH'(m_w);
                    ent.mwe  = 1'b1;
                    ent.addr = AWIDTH'((m_base + k) % (1 << AWIDTH));
                    ent.busy = 1'b1;
                    mq.push_back(ent);
                end
                m_ptr = (m_w + 1) % NREQ;
            end
            if (mq.size() > 0) begin
                exp_o = mq.pop_front();
            end else begin
                exp_o.gnt  = '0;
                exp_o.swe  = 1'b0;
                exp_o.mwe  = 1'b0;
                exp_o.busy = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (xrst) begin
            check("gnt", 32'(gnt), 32'(exp_o.gnt));
            check("sel", 32'(sel), 32'(exp_o.sel));
            check("serial_we", 32'(serial_we), 32'(exp_o.swe));
            check("mem_we", 32'(mem_we), 32'(exp_o.mwe));
            check("busy", 32'(busy), 32'(exp_o.busy));
            if (exp_o.mwe) check("mem_addr", 32'(mem_addr), 32'(exp_o.addr));
        end
    end

    // Log of what the DUT actually did, for the literal scenario checks.
    int cyc = 0;
    int wr_log[$];
    int gnt_log[$];
    int gnt_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (xrst) begin
            if (mem_we) wr_log.push_back(int'(mem_addr));
            if (gnt != '0) begin
                gnt_log.push_back(int'(sel));
                gnt_cyc.push_back(cyc);
            end
        end
    end

    logic [NREQ-1:0] hold;

    task automatic clear_logs();
        wr_log.delete();
        gnt_log.delete();
        gnt_cyc.delete();
    endtask

    // One cycle of requester behaviour: drop req after its grant unless held.
    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i] && !hold[i]) req[i] = 1'b0;
        end
    endtask

    task automatic set_req(input int i, input int len, input int base);
        req_len[i*LWIDTH +: LWIDTH]  = LWIDTH'(len);
        req_base[i*AWIDTH +: AWIDTH] = AWIDTH'(base);
        req[i] = 1'b1;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while ((req != '0 || busy) && n < budget);
        check({name, "_idle_timeout"}, 32'(n < budget), 32'd1);
    endtask

    task automatic wait_gnt(input int i, input int budget);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!gnt[i] && n < budget);
        check("gnt_wait_timeout", 32'(n < budget), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        xrst = 1'b0;
        req  = '0;
        hold = '0;
        repeat (2) @(negedge clk);
        xrst = 1'b1;
    endtask

    initial begin
        xrst     = 1'b0;
        req      = '0;
        hold     = '0;
        req_len  = '0;
        req_base = '0;
        repeat (3) @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        xrst = 1'b1;
        tick();

        // Round robin with all four requesting continuously.
        clear_logs();
        hold = '1;
        for (int i = 0; i < NREQ; i++) set_req(i, 4, 16'h040 * (i + 1));
        for (int n = 0; n < 60 && gnt_log.size() < 5; n++) tick();
        hold = '0;
        req  = '0;
        wait_idle("rr", 40);
        check("rr_count_ge5", 32'(gnt_log.size() >= 5), 32'd1);
        if (gnt_log.size() >= 5) begin
            for (int i = 0; i < 5; i++) check("rr_order", 32'(gnt_log[i]), 32'(i % NREQ));
            for (int i = 0; i < 4; i++) check("rr_period", 32'(gnt_cyc[i+1] - gnt_cyc[i]), 32'd5);
        end

        // Full vector from requester 0.
        do_reset();
        tick();
        clear_logs();
        set_req(0, 16, 12'h100);
        wait_idle("full", 40);
        check("full_gnts", 32'(gnt_log.size()), 32'd1);
        check("full_writes", 32'(wr_log.size()), 32'd16);
        if (wr_log.size() == 16) begin
            check("full_first", 32'(wr_log[0]), 32'h100);
            check("full_last", 32'(wr_log[15]), 32'h10F);
        end

        // Partial vector crossing the top of the address space.
        clear_logs();
        set_req(2, 3, 12'hFFE);
        wait_idle("wrap", 40);
        check("wrap_writes", 32'(wr_log.size()), 32'd3);
        if (wr_log.size() == 3) begin
            check("wrap_a0", 32'(wr_log[0]), 32'hFFE);
            check("wrap_a1", 32'(wr_log[1]), 32'hFFF);
            check("wrap_a2", 32'(wr_log[2]), 32'h000);
        end

        // Zero and oversize lengths both mean a full vector.
        clear_logs();
        set_req(1, 0, 12'h200);
        wait_idle("len0", 40);
        check("len0_writes", 32'(wr_log.size()), 32'd16);
        clear_logs();
        set_req(1, 20, 12'h300);
        wait_idle("len20", 40);
        check("len20_writes", 32'(wr_log.size()), 32'd16);

        // Late request arriving in the final write cycle of another vector.
        clear_logs();
        set_req(1, 4, 12'h400);
        wait_gnt(1, 10);
        repeat (4) tick();
        set_req(3, 2, 12'h500);
        wait_idle("late", 40);
        check("late_gnts", 32'(gnt_log.size()), 32'd2);
        if (gnt_log.size() == 2) begin
            check("late_who", 32'(gnt_log[1]), 32'd3);
            check("late_gap", 32'(gnt_cyc[1] - gnt_cyc[0]), 32'd5);
        end
        check("late_writes", 32'(wr_log.size()), 32'd6);

        // Asynchronous reset in the middle of a transfer.
        do_reset();
        tick();
        clear_logs();
        set_req(0, 16, 12'h040);
        wait_gnt(0, 10);
        repeat (6) tick();
        check("pre_rst_we", 32'(mem_we), 32'd1);
        xrst = 1'b0;
        #1;
        check("arst_mem_we", 32'(mem_we), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_addr", 32'(mem_addr), 32'd0);
        check("arst_sel", 32'(sel), 32'd0);
        repeat (2) tick();
        xrst = 1'b1;
        clear_logs();
        repeat (5) tick();
        check("post_rst_writes", 32'(wr_log.size()), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);
        set_req(0, 2, 12'h010);
        set_req(3, 2, 12'h020);
        wait_idle("ptr", 40);
        check("ptr_gnts", 32'(gnt_log.size()), 32'd2);
        if (gnt_log.size() == 2) begin
            check("ptr_first", 32'(gnt_log[0]), 32'd0);
            check("ptr_second", 32'(gnt_log[1]), 32'd3);
        end

        // Randomized traffic, checked cycle by cycle against the model.
        for (int n = 0; n < 1500; n++) begin
            hold = NREQ'($urandom_range(0, (1 << NREQ) - 1) & $urandom_range(0, (1 << NREQ) - 1));
            tick();
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i] && !gnt[i] && $urandom_range(0, 3) == 0)
                    set_req(i, int'($urandom_range(0, 20)), int'($urandom_range(0, (1 << AWIDTH) - 1)));
            end
        end
        hold = '0;
        wait_idle("rand", 400);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
